// File: rtl/mul32_seq_ctrl.sv
// Iterative 32x32 unsigned shift-add multiplier returning the low product word.
// Optional build macro MUL_EARLY_EXIT_EN ends iteration once the remaining multiplier bits are zero.

module simple_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  assign sum = a + b;
endmodule

// Handshake: start is accepted only while busy=0 (IDLE or DONE); busy stays high
// while iterating and start is then ignored; done pulses one cycle with result valid.
module mul32_seq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] acc_q;
  logic [31:0] result_q;
  logic [5:0]  count_q;

  logic [31:0] sum;
  logic [31:0] acc_d;
  logic [31:0] mplier_d;
  logic        last_iter;

  simple_adder32 u_adder (
    .a   (acc_q),
    .b   (mcand_q),
    .sum (sum)
  );

  assign acc_d    = mplier_q[0] ? sum : acc_q;
  assign mplier_d = {1'b0, mplier_q[31:1]};

`ifdef MUL_EARLY_EXIT_EN
  assign last_iter = (count_q == 6'd31) || (mplier_d == 32'd0);
`else
  assign last_iter = (count_q == 6'd31);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      count_q  <= 6'd0;
      result_q <= 32'd0;
    end else begin
      case (state_q)
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[30:0], 1'b0};
          mplier_q <= mplier_d;
          count_q  <= count_q + 6'd1;
          if (last_iter) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= acc_d;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request
          if (start) begin
            state_q  <= BUSY;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= 32'd0;
            count_q  <= 6'd0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign state_dbg = state_q;
endmodule

// File: doc/mul32_seq_ctrl.md
# mul32_seq_ctrl

Iterative 32×32 unsigned multiply controller for the processor's execute stage. It reuses one `simple_adder32` instance as its only arithmetic element and sequences it through a shift-add loop, one multiplier bit per clock. It returns the low 32 bits of the product, which are the MUL result. A start/busy/done handshake lets the pipeline control logic stall while the multiply runs.

## Interface
- No parameters; width fixed at 32.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge.
- `start`  in  1  request; accepted only when `busy`=0.
- `a`  in  32  multiplicand; captured on the accepting edge.
- `b`  in  32  multiplier; captured on the accepting edge.
- `busy`  out  1  high while iterating; new `start` ignored.
- `done`  out  1  one-cycle pulse; `result` valid.
- `result`  out  32  low 32 bits of a×b; holds until the next accepted `start` completes.

## Operation
- State machine with three states: IDLE, BUSY, DONE.
- Registers:
  - `mcand` (32b): shifts left each iteration.
  - `mplier` (32b): shifts right each iteration.
  - `acc` (32b).
  - `count` (6b).
  - `result` (32b).
- Adder hookup: one `simple_adder32` with A=`acc` and B=`mcand`.
  - `sum` is mod 2^32.
  - There is no carry out, and none is needed for a low-word product.
- IDLE or DONE with `start`=1:
  - load `mcand`←a, `mplier`←b, `acc`←0, `count`←0.
  - go to BUSY.
- IDLE or DONE with `start`=0:
  - IDLE stays in IDLE.
  - DONE goes to IDLE.
- BUSY, on each edge:
  - `acc` ← `mplier[0]` ? `sum` : `acc`.
  - `mcand` ← `mcand`<<1, `mplier` ← `mplier`>>1, `count` ← `count`+1.
  - When `count`=31 (the 32nd iteration), go to DONE and load `result` with the updated `acc` value (same as `acc`'s next value).
- `start` while BUSY is ignored and is not queued. Operand inputs are don't-care while BUSY.
- Outputs are Moore-decoded from state:
  - `busy`=1 in BUSY only.
  - `done`=1 in DONE only.
- Reset in any state, including mid-BUSY:
  - next state IDLE.
  - `busy`=0, `done`=0, `result`=0.
  - `acc`, `mcand`, `mplier`, `count` all 0.
  - The in-flight operation is discarded and never produces `done`.
- Arithmetic: unsigned. Signed MUL low word is identical, so no sign handling is required.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE.
- `start` is sampled at the end of cycle 0. Then:
  - `busy`=1 in cycles 1–32.
  - `done`=1 in cycle 33 with `result` valid.
  - `busy`=0 in cycle 33.
- Latency is start edge → `done` = 33 cycles.
- Back-to-back operation:
  - `start` in the DONE cycle is accepted.
  - `busy` rises in cycle 34.
  - `done` is still a single-cycle pulse.
- `result` changes only on the edge that enters DONE (or on reset). It is stable in all other cycles.
- No combinational path from inputs to outputs.

## Configuration
- `MUL_EARLY_EXIT_EN` defined:
  - In BUSY, if the shifted `mplier` value (`mplier`>>1) is 0, go to DONE on that edge regardless of `count`, and load `result`.
  - BUSY lasts msb(b)+1 cycles, with b=0 counting as msb 0.
  - `done` appears in cycle msb(b)+2.
- `MUL_EARLY_EXIT_EN` undefined:
  - Fixed 32 BUSY cycles.
  - `done` always in cycle 33.
- `result` values are identical in both builds.

## Test plan
- Reset, then a=3, b=5, `start` pulse in cycle 0 → `busy` cycles 1–32, `done` only in cycle 33, `result`=0x0000000F (early exit: `done` in cycle 4).
- a=0xFFFFFFFF, b=0xFFFFFFFF → `result`=0x00000001; a=0x80000000, b=2 → `result`=0x00000000 (wrap).
- Issue a=7, b=2; assert `start` with a=9, b=9 in cycle 10 → `result`=0x0000000E. Only one `done` pulse; the second request is dropped.
- Start a=6, b=7; assert `reset` in cycle 15 → cycle 16: `busy`=0, `done`=0, `result`=0. No `done` in cycles 16–40.
- `start` a=4, b=4, then `start` a=2, b=3 held in the DONE cycle → first `done` with `result`=0x10. Second `done` 33 cycles later with `result`=0x6.
- `MUL_EARLY_EXIT_EN` build: a=7, b=2 → `done` in cycle 3, `result`=0xE. a=5, b=0 → `done` in cycle 2, `result`=0.
